// File: rtl/sdm_sample_sequencer.sv
// -----------------------------------------------------------------------------
// sdm_sample_sequencer
//   Feeds the second-order 1-bit SDM DAC with one sample every `osr` clocks.
//   Samples arrive over valid/ready and are buffered in a small FIFO. Start and
//   stop are slew-limited (RAMP_STEP per update) so the output never clicks;
//   on FIFO underrun the last value is held and counted.
//
// Ports
//   clk          sequencer / SDM clock
//   areset       synchronous active-low reset
//   en           play enable
//   osr          update period in clocks (0 and 1 behave as 2)
//   s_valid      upstream sample valid
//   s_data       upstream sample, signed
//   s_ready      sample accepted when s_valid && s_ready at posedge
//   dout         signed sample to SDM din
//   dout_stb     one-cycle pulse coincident with each dout update
//   underrun_cnt saturating count of RUN ticks that found the FIFO empty
//   fifo_level   current FIFO occupancy
//   state        IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
// -----------------------------------------------------------------------------
module sdm_sample_sequencer #(
    parameter int N          = 16,
    parameter int OSR_W      = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int RAMP_STEP  = 64
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          en,
    input  logic [OSR_W-1:0]              osr,
    input  logic                          s_valid,
    input  logic [N-1:0]                  s_data,
    output logic                          s_ready,
    output logic [N-1:0]                  dout,
    output logic                          dout_stb,
    output logic [7:0]                    underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [N:0] STEP = (N+1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t cur, nxt;

    // FIFO storage and bookkeeping
    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, push, pop, flush;
    logic [N-1:0]  head;

    // Update-rate timing
    logic [OSR_W-1:0] cnt, period, osr_clamped;
    logic             tick;

    // Slew datapath
    logic [N-1:0]     target, slew_tgt, slew_res;
    logic signed [N:0] diff;
    logic             primed;   // RAMP_UP has already popped its target

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign head        = mem[rd_ptr];
    assign push        = s_valid && s_ready;
    assign osr_clamped = (osr < OSR_W'(2)) ? OSR_W'(2) : osr;
    assign fifo_level  = count;
    assign state       = cur;

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (!areset) cur <= IDLE;
        else         cur <= nxt;
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        // NOTE: default assignment first so no path leaves nxt unassigned,
        // which would otherwise infer a latch.
        nxt = cur;
        unique case (cur)
            IDLE:      if (en && !empty)                    nxt = RAMP_UP;
            RAMP_UP:   if (!en)                             nxt = RAMP_DOWN;
                       else if (tick && slew_res == slew_tgt) nxt = RUN;
            RUN:       if (!en)                             nxt = RAMP_DOWN;
            RAMP_DOWN: if (tick && slew_res == '0)          nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs / controls
    always_comb begin
        tick     = (cur != IDLE) && (cnt == period - OSR_W'(1));
        s_ready  = en && !full && (cur != RAMP_DOWN);
        pop      = tick && !empty && ((cur == RAMP_UP && !primed) || cur == RUN);
        flush    = (cur == RAMP_DOWN) && (nxt == IDLE);
        slew_tgt = target;
        if (cur == RAMP_UP && !primed) slew_tgt = head;   // first ramp tick slews toward the fresh pop
        else if (cur == RAMP_DOWN)     slew_tgt = '0;
    end

    // Slew toward slew_tgt by at most RAMP_STEP; diff is one bit wider so the
    // subtraction cannot overflow, and stepping toward an in-range target
    // can never wrap past full scale.
    always_comb begin
        diff = $signed({slew_tgt[N-1], slew_tgt}) - $signed({dout[N-1], dout});
        if (diff > STEP)       slew_res = dout + STEP[N-1:0];
        else if (diff < -STEP) slew_res = dout - STEP[N-1:0];
        else                   slew_res = slew_tgt;
    end

    // ---------------------------------------------------------------- FIFO
    // NOTE: the sample memory has no reset; validity is tracked entirely by
    // count and the pointers, so clearing those discards the contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!areset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // ---------------------------------------------------------------- timing + datapath
    always_ff @(posedge clk) begin
        if (!areset) begin
            cnt          <= '0;
            period       <= OSR_W'(2);
            dout         <= '0;
            dout_stb     <= 1'b0;
            target       <= '0;
            primed       <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            dout_stb <= tick;

            // Period is only re-sampled on start-up and at each tick.
            if (cur == IDLE) begin
                cnt <= '0;
                if (nxt == RAMP_UP) period <= osr_clamped;
            end else if (tick) begin
                cnt    <= '0;
                period <= osr_clamped;
            end else begin
                cnt <= cnt + OSR_W'(1);
            end

            unique case (cur)
                IDLE: begin
                    dout   <= '0;
                    target <= '0;
                    primed <= 1'b0;
                end
                RAMP_UP: if (tick) begin
                    if (!primed) begin
                        target <= head;
                        primed <= 1'b1;
                    end
                    dout <= slew_res;
                end
                RUN: if (tick) begin
                    if (!empty)                 dout <= head;
                    else if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                end
                RAMP_DOWN: begin
                    target <= '0;
                    if (tick) dout <= slew_res;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdm_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdm_sample_sequencer
//   Directed bench for sdm_sample_sequencer: ramp-up, RUN playback, underrun
//   saturation, full-scale ramp-down, negative clamp, osr clamping and reload
//   timing, FIFO full / simultaneous push+pop, and reset mid-ramp. Expected
//   values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sdm_sample_sequencer;

    localparam int N          = 16;
    localparam int OSR_W      = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int RAMP_STEP  = 64;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             areset, en, s_valid, s_ready, dout_stb;
    logic [OSR_W-1:0] osr;
    logic [N-1:0]     s_data, dout;
    logic [7:0]       underrun_cnt;
    logic [LW-1:0]    fifo_level;
    logic [1:0]       state;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    sdm_sample_sequencer #(
        .N(N), .OSR_W(OSR_W), .FIFO_DEPTH(FIFO_DEPTH), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk), .areset(areset), .en(en), .osr(osr),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .dout(dout), .dout_stb(dout_stb), .underrun_cnt(underrun_cnt),
        .fifo_level(fifo_level), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until a dout strobe (bounded); returns the number of clocks taken.
    task automatic wait_stb(input string tag, input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!dout_stb && cycles < budget);
        check({tag, "_stb"}, 32'(dout_stb), 32'd1);
    endtask

    task automatic push(input logic [N-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        areset = 1'b0; en = 1'b0; osr = 10'd4; s_valid = 1'b0; s_data = '0;
        step(); step();

        // ---- reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_dout",  32'(dout), 32'd0);
        check("rst_stb",   32'(dout_stb), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_under", 32'(underrun_cnt), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        areset = 1'b1;
        en = 1'b1;
        #1;
        check("idle_ready", 32'(s_ready), 32'd1);

        // ---- preload and ramp up to 0x1000 at osr=4
        push(16'h1000);
        push(16'h2000);
        push(16'h2000);
        push(16'h2000);
        check("preload_level", 32'(fifo_level), 32'd4);
        check("preload_state", 32'(state), 32'd1);
        for (int k = 1; k <= 64; k++) begin
            wait_stb("up", 20, n);
            check("up_dout", 32'(dout), 32'(16'(64 * k)));
            if (k > 1) check("up_gap", 32'(n), 32'd4);
            if (k == 1) check("up_pop_level", 32'(fifo_level), 32'd3);
        end
        check("up_to_run", 32'(state), 32'd2);
        for (int k = 0; k < 3; k++) begin
            wait_stb("run", 20, n);
            check("run_dout", 32'(dout), 32'h2000);
            check("run_gap", 32'(n), 32'd4);
        end
        check("run_level", 32'(fifo_level), 32'd0);

        // ---- underrun with osr changed to 3
        osr = 10'd3;
        wait_stb("ur1", 20, n);
        check("ur1_gap", 32'(n), 32'd4);
        check("ur1_cnt", 32'(underrun_cnt), 32'd1);
        check("ur1_hold", 32'(dout), 32'h2000);
        wait_stb("ur2", 20, n);
        check("ur2_gap", 32'(n), 32'd3);
        check("ur2_cnt", 32'(underrun_cnt), 32'd2);
        for (int k = 3; k <= 255; k++) wait_stb("ur", 20, n);
        check("ur_255", 32'(underrun_cnt), 32'd255);
        for (int k = 0; k < 5; k++) wait_stb("ursat", 20, n);
        check("ur_sat", 32'(underrun_cnt), 32'd255);
        check("ur_hold", 32'(dout), 32'h2000);

        // ---- full-scale ramp-down from 0x7FC0 with a stale entry to flush
        push(16'h7FC0);
        push(16'h1234);
        wait_stb("fs", 20, n);
        check("fs_dout", 32'(dout), 32'h7FC0);
        check("fs_level", 32'(fifo_level), 32'd1);
        en = 1'b0;
        step();
        check("dn_state", 32'(state), 32'd3);
        en = 1'b1;
        #1;
        check("dn_ready", 32'(s_ready), 32'd0);
        for (int k = 1; k <= 511; k++) begin
            wait_stb("dn", 20, n);
            check("dn_dout", 32'(dout), 32'(16'(32704 - 64 * k)));
        end
        check("dn_idle", 32'(state), 32'd0);
        check("dn_flush", 32'(fifo_level), 32'd0);

        // ---- negative target: -64, -100, then ramp down -36, 0
        push(16'hFF9C);
        wait_stb("neg1", 20, n);
        check("neg1_dout", 32'(dout), 32'hFFC0);
        check("neg1_state", 32'(state), 32'd1);
        wait_stb("neg2", 20, n);
        check("neg2_dout", 32'(dout), 32'hFF9C);
        check("neg2_state", 32'(state), 32'd2);
        en = 1'b0;
        step();
        check("neg_dn_state", 32'(state), 32'd3);
        wait_stb("neg3", 20, n);
        check("neg3_dout", 32'(dout), 32'hFFDC);
        wait_stb("neg4", 20, n);
        check("neg4_dout", 32'(dout), 32'h0000);
        check("neg4_state", 32'(state), 32'd0);

        // ---- osr clamping and reload timing
        osr = 10'd0;
        en  = 1'b1;
        push(16'h0005);
        wait_stb("o0a", 20, n);
        check("o0_dout", 32'(dout), 32'h0005);
        check("o0_state", 32'(state), 32'd2);
        wait_stb("o0b", 20, n);
        check("o0_gap1", 32'(n), 32'd2);
        wait_stb("o0c", 20, n);
        check("o0_gap2", 32'(n), 32'd2);
        osr = 10'd1;
        wait_stb("o1a", 20, n);
        check("o1_gap1", 32'(n), 32'd2);
        wait_stb("o1b", 20, n);
        check("o1_gap2", 32'(n), 32'd2);
        osr = 10'd4;
        wait_stb("o4a", 20, n);
        check("o4_gap_old", 32'(n), 32'd2);
        wait_stb("o4b", 20, n);
        check("o4_gap_new", 32'(n), 32'd4);
        step();
        osr = 10'd6;
        wait_stb("o6a", 20, n);
        check("o6_gap_mid", 32'(n), 32'd3);
        wait_stb("o6b", 20, n);
        check("o6_gap_new", 32'(n), 32'd6);

        // ---- FIFO full and push+pop at level 5
        en = 1'b0;
        step();
        wait_stb("stop", 20, n);
        check("stop_state", 32'(state), 32'd0);
        osr = 10'd1000;
        en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(16'(10 + i));
            check("fill_level", 32'(fifo_level), 32'(i + 1));
        end
        check("full_ready", 32'(s_ready), 32'd0);
        push(16'h0099);
        check("full_hold", 32'(fifo_level), 32'd8);
        osr = 10'd4;
        wait_stb("f1", 1100, n);
        check("f1_dout", 32'(dout), 32'd10);
        check("f1_state", 32'(state), 32'd2);
        check("f1_level", 32'(fifo_level), 32'd7);
        wait_stb("f2", 20, n);
        check("f2_dout", 32'(dout), 32'd11);
        wait_stb("f3", 20, n);
        check("f3_dout", 32'(dout), 32'd12);
        check("f3_level", 32'(fifo_level), 32'd5);
        step(); step(); step();
        push(16'h0055);
        check("pp_stb", 32'(dout_stb), 32'd1);
        check("pp_dout", 32'(dout), 32'd13);
        check("pp_level", 32'(fifo_level), 32'd5);

        // ---- reset mid RAMP_UP
        en = 1'b0;
        step();
        wait_stb("stop2", 20, n);
        check("stop2_state", 32'(state), 32'd0);
        check("stop2_flush", 32'(fifo_level), 32'd0);
        en = 1'b1;
        push(16'h4000);
        wait_stb("r1", 20, n);
        check("r1_dout", 32'(dout), 32'd64);
        wait_stb("r2", 20, n);
        check("r2_dout", 32'(dout), 32'd128);
        check("r2_state", 32'(state), 32'd1);
        areset = 1'b0;
        step();
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_stb", 32'(dout_stb), 32'd0);
        check("mid_rst_under", 32'(underrun_cnt), 32'd0);
        areset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(s_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdm_sample_sequencer.md
Name: sdm_sample_sequencer

Overview:
- Feeds the second-order 1-bit SDM DAC with samples at a programmable update rate (one sample per OSR clocks).
- Accepts samples from upstream over valid/ready and buffers them in a small FIFO.
- Applies click-free slew ramps on start and stop, and holds the last value when the FIFO underruns.
- Sits between the audio/sample source and the SDM din input, in the SDM clock domain.

Parameters:
N, 16, sample width (signed two's complement), equal to the SDM N
OSR_W, 10, width of the update-period register
FIFO_DEPTH, 8, sample FIFO entries (power of 2, >=2)
RAMP_STEP, 64, maximum |dout| change per update tick during ramps (positive, < 2^(N-1))

Ports:
clk  in  1  sequencer and SDM clock
areset  in  1  synchronous active-low reset
en  in  1  play enable
osr  in  OSR_W  update period in clk cycles; 0 and 1 are treated as 2
s_valid  in  1  upstream sample valid
s_data  in  N  upstream sample, signed
s_ready  out  1  sample accepted when s_valid && s_ready at posedge
dout  out  N  signed sample to SDM din
dout_stb  out  1  one-cycle pulse, coincident with each dout update
underrun_cnt  out  8  saturating count of ticks in RUN with an empty FIFO
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
state  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3

Behaviour:
- Reset: one clock; areset synchronous active-low, sampled at posedge clk only.
- Reset values: state=IDLE, dout=0, dout_stb=0, underrun_cnt=0, FIFO empty (fifo_level=0), tick counter=0, target=0. s_ready is combinational and follows from the registered state.
- Reset asserted mid-operation: all of the above apply at the next edge. FIFO contents are discarded.
- s_ready = en && !full && state!=RAMP_DOWN.
- Push when s_valid && s_ready. Pop only on a tick as defined below.
- Simultaneous push and pop leaves fifo_level unchanged. A push while full is impossible because s_ready is low.
- Tick counter: held at 0 in IDLE; otherwise counts 0..period-1. A tick occurs in the cycle cnt==period-1.
- period is loaded from the clamped osr on the IDLE->RAMP_UP transition and at every tick. Changes to osr take effect only at those points.
- On a tick: dout and dout_stb are registered together, so dout changes and dout_stb=1 in the same cycle (one cycle after the tick cycle). dout_stb=0 otherwise.
- Slew step: diff = target - dout, computed in N+1 bits.
  - If |diff| <= RAMP_STEP: dout = target.
  - Otherwise: dout = dout ± RAMP_STEP.
  - No wrap-around is permitted at the ±full-scale ends.
- IDLE: dout=0. Pushes are accepted while en=1 (preload). Transition to RAMP_UP when en=1 && fifo_level>0.
- RAMP_UP:
  - First tick: pop the FIFO head into target, then slew.
  - Subsequent ticks: slew only; no pop.
  - Go to RUN on the tick where dout reaches target.
  - If en=0, go to RAMP_DOWN at the next edge.
- RUN, on each tick:
  - FIFO non-empty: pop; dout = popped value directly (no slew).
  - FIFO empty: dout holds, and underrun_cnt increments, saturating at 255.
  - If en=0, go to RAMP_DOWN at the next edge. A tick in that same cycle is still processed as RUN.
- RAMP_DOWN:
  - target=0; slew on each tick; no pops; s_ready=0.
  - When dout==0 after a tick, go to IDLE and flush the FIFO (level=0).
  - en re-asserting during RAMP_DOWN is ignored until IDLE is reached; IDLE then restarts normally.
- underrun_cnt clears only on reset.

Test Plan:
- Reset, osr=4, en=1, push 0x1000 then three samples of 0x2000 → RAMP_UP.
  - dout_stb every 4 clocks; dout climbs 64,128,… to 0x1000 in 64 ticks, then RUN.
  - Subsequent ticks output 0x2000 ×3.
- RUN, osr=3, FIFO empties → dout holds the last value; underrun_cnt increments once per tick; saturates at 255 after 255+ ticks.
- RUN with dout=0x7FC0, drop en → 0x7F80, 0x7F40, … down to 0, then IDLE. FIFO level is 0 afterwards. No wrap occurs.
- Negative ramp, dout=-100, RAMP_STEP=64, target 0 → -36 then 0 (exact clamp).
- osr=0 and osr=1 → ticks every 2 clocks. Change osr from 4 to 6 mid-period → new period begins only after the current tick.
- Push 8 samples with no ticks → s_ready low at level 8. Push and tick in the same cycle at level 5 → level stays 5. Assert areset mid-RAMP_UP → next edge dout=0, state=0, level=0.
